router_local_input_port: RTL
============================

ROUTER_LOCAL_INPUT_PORT -- requirements
Module: router_local_input_port

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits (matches router flit width).
REQ-002 SHALL have parameter ADDR_W, default 6, destination PE index width held in flit[FLIT_W-1 -: ADDR_W].
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries (power of two, >=2); equals credits granted to the PE at reset.
REQ-004 SHALL have parameter SUB_LO, default 0, lowest PE index served downward by this router.
REQ-005 SHALL have parameter SUB_HI, default 3, highest PE index served downward by this router.
REQ-006 SHALL have port clk  input  1  system clock; one clock only.
REQ-007 SHALL have port rst  input  1  system reset, synchronous, active-high.
REQ-008 SHALL have port in_data_valid  input  1  flit valid from the PE network interface.
REQ-009 SHALL have port in_data  input  FLIT_W  flit from the PE.
REQ-010 SHALL have port upstream_credit  output  1  one-cycle credit pulse back to the PE.
REQ-011 SHALL have port out_valid  output  1  head flit available to the switch.
REQ-012 SHALL have port out_flit  output  FLIT_W  head flit.
REQ-013 SHALL have port out_route  output  1  head route: 0 = down (child), 1 = up (parent).
REQ-014 SHALL have port out_grant  input  1  switch accepts head flit this cycle.
REQ-015 SHALL have port overflow  output  1  sticky error: flit arrived with no free entry.
REQ-016 SHALL have port flit_cnt  output  16  accepted-flit count, saturating.

Function
REQ-017 SHALL store flits in a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy count 0..DEPTH.
REQ-018 Push: in_data_valid=1 and (count<DEPTH, or count==DEPTH with pop in same cycle) -> flit written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Pop: out_grant=1 and out_valid=1 -> rd_ptr increments modulo DEPTH; out_grant while out_valid=0 SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push only +1; pop only -1.
REQ-021 in_data_valid=1 with count==DEPTH and no pop SHALL drop the flit, leave FIFO unchanged and set overflow=1 until reset.
REQ-022 out_valid SHALL equal (count!=0); out_flit SHALL be the entry at rd_ptr, combinational from storage, no added latency.
REQ-023 A flit pushed in cycle N SHALL appear on out_flit/out_valid in cycle N+1 when FIFO was empty (one-cycle latency, no bypass).
REQ-024 out_route SHALL be 0 when SUB_LO <= dest <= SUB_HI, else 1, dest = out_flit[FLIT_W-1 -: ADDR_W], unsigned compare.
REQ-025 out_route SHALL be 0 whenever out_valid=0.
REQ-026 upstream_credit SHALL be registered: pop in cycle N -> upstream_credit=1 in cycle N+1 only; one pulse per pop, back-to-back pops give back-to-back pulses.
REQ-027 flit_cnt SHALL increment by 1 per accepted push and hold at 16'hFFFF; dropped flits not counted.
REQ-028 Storage contents SHALL need no reset; only pointers, count and outputs are reset.

Reset
REQ-029 rst=1 at a clock edge SHALL set wr_ptr=0, rd_ptr=0, count=0, upstream_credit=0, overflow=0, flit_cnt=0, hence out_valid=0, out_route=0.
REQ-030 Reset mid-operation SHALL discard all buffered flits; no credit pulses for discarded flits; pushes/grants during rst=1 SHALL be ignored.
REQ-031 First cycle after rst deasserts SHALL accept a push.

Verification
REQ-032 Single flit, dest=2: push cycle 0 -> cycle 1 out_valid=1, out_route=0; grant cycle 1 -> cycle 2 upstream_credit=1, out_valid=0, flit_cnt=1.
REQ-033 Fill: 4 pushes no grant, dest=9 -> count=4, out_route=1, 5th push sets overflow=1, flit_cnt=4, head still first flit.
REQ-034 Full with simultaneous push+grant -> push accepted, overflow stays 0, count stays 4, one credit pulse next cycle.
REQ-035 Stream 10 flits with grant held high, increasing payloads -> output order identical, 10 credit pulses, pointer wrap correct.
REQ-036 Reset with 3 flits buffered and grant high -> next cycle out_valid=0, upstream_credit=0, flit_cnt=0, overflow=0.
REQ-037 Grant while empty -> no pointer change, no credit pulse.

Source files
------------

// File: rtl/router_local_input_port.sv
// Local (PE-side) input port of a tree router: a DEPTH-entry flit FIFO with
// credit return, head-flit route decode and a saturating accepted-flit count.
module router_local_input_port #(
  parameter int FLIT_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4,
  parameter int SUB_LO = 0,
  parameter int SUB_HI = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              upstream_credit,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_route,
  input  logic              out_grant,
  output logic              overflow,
  output logic [15:0]       flit_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE = (PTR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LO_C    = ADDR_W'(SUB_LO);
  localparam logic [ADDR_W-1:0] HI_C    = ADDR_W'(SUB_HI);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              credit_p1;
  logic              push;
  logic              pop;
  logic              full;
  logic [ADDR_W-1:0] dest;
  logic              in_sub;

  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_grant && out_valid && !rst;
  assign push      = in_data_valid && !rst && (!full || pop);

  assign out_flit = mem[rd_ptr];
  assign dest     = out_flit[FLIT_W-1 -: ADDR_W];
  // A constant 1 MSB on both sides keeps the lower-bound compare meaningful when SUB_LO is 0.
  assign in_sub    = ({1'b1, dest} >= {1'b1, LO_C}) && (dest <= HI_C);
  assign out_route = out_valid && !in_sub;

  // Storage stage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Control stage: pointers, occupancy, credit, error and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      credit_p1 <= 1'b0;
      overflow  <= 1'b0;
      flit_cnt  <= '0;
    end else begin
      credit_p1 <= pop;
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        flit_cnt <= sat_inc(flit_cnt);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (in_data_valid && !push) overflow <= 1'b1;
    end
  end

  assign upstream_credit = credit_p1;

endmodule
